intersection_request_scheduler: RTL and testbench

Sequences pedestrian-crossing and emergency-vehicle (EMV) requests against the signal cycle of the intersection traffic controller. Latches asynchronous requests, decides when each may be served, and drives the controller's preempt/hold inputs. Also drives the pedestrian WALK/FLASH indications. Sits between the field request inputs and the traffic controller, in the same tick domain.

---
 rtl/intersection_request_scheduler_if.sv | 26 ++
 rtl/intersection_request_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_intersection_request_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_request_scheduler_if.sv
// Bundle of field request, controller status and scheduler command signals
// between the intersection controller and the request scheduler.
interface intersection_request_scheduler_if;
    logic [1:0] ped_req;
    logic [1:0] emv_req;
    logic [1:0] active_phase;
    logic       yellow;
    logic       all_red;
    logic       preempt;
    logic       preempt_phase;
    logic       hold_green;
    logic [1:0] ped_pending;
    logic [1:0] ped_walk;
    logic [1:0] ped_flash;
    logic       emv_timeout;

    modport slave (
        input  ped_req, emv_req, active_phase, yellow, all_red,
        output preempt, preempt_phase, hold_green, ped_pending, ped_walk, ped_flash, emv_timeout
    );

    modport master (
        output ped_req, emv_req, active_phase, yellow, all_red,
        input  preempt, preempt_phase, hold_green, ped_pending, ped_walk, ped_flash, emv_timeout
    );
endinterface

// File: rtl/intersection_request_scheduler.sv
// Schedules pedestrian WALK/FLASH service and emergency-vehicle preemption
// against the traffic controller's signal cycle; all outputs are registered.
module intersection_request_scheduler #(
    parameter int unsigned WALK_TICKS    = 700,
    parameter int unsigned FLASH_TICKS   = 500,
    parameter int unsigned EMV_MIN_TICKS = 500,
    parameter int unsigned EMV_MAX_TICKS = 6000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    intersection_request_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WALK, S_FLASH, S_EMV_SEEK, S_EMV_HOLD, S_EMV_LOCK
    } state_t;

    // Down-counter is loaded with duration-1 so a phase lasts exactly its tick count.
    localparam logic [15:0] WALK_LOAD  = 16'(WALK_TICKS - 1);
    localparam logic [15:0] FLASH_LOAD = 16'(FLASH_TICKS - 1);
    localparam logic [15:0] MIN_LOAD   = 16'(EMV_MIN_TICKS - 1);
    localparam logic [15:0] EMV_MAX    = 16'(EMV_MAX_TICKS);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        walk_p_q, walk_p_d;
    logic        target_q, target_d;
    logic [1:0]  green_q, green_d;
    logic [1:0]  pending_q, pending_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  walk_q, walk_d;
    logic [1:0]  flash_q, flash_d;
    logic        hold_q, hold_d;
    logic        preempt_q, preempt_d;
    logic        pphase_q, pphase_d;

    logic [1:0]  green_rise;
    logic [1:0]  ped_clr;
    logic        cnt_done, pcnt_max, emv_any, emv_sel, seek_entry, in_preempt;

    assign green_d[0] = (bus.active_phase == 2'd0) && !bus.yellow && !bus.all_red;
    assign green_d[1] = (bus.active_phase == 2'd1) && !bus.yellow && !bus.all_red;
    assign green_rise = green_d & ~green_q;
    assign cnt_done   = (cnt_q == 16'd0);
    assign pcnt_max   = (pcnt_q >= EMV_MAX);
    assign emv_any    = |bus.emv_req;
    assign emv_sel    = !bus.emv_req[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        walk_p_d  = walk_p_q;
        target_d  = target_q;
        ped_clr   = 2'b00;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (emv_any) begin
                    state_d  = S_EMV_SEEK;
                    target_d = emv_sel;
                end else if (green_rise[0] && pending_q[0]) begin
                    state_d    = S_WALK;
                    walk_p_d   = 1'b0;
                    ped_clr[0] = 1'b1;
                end else if (green_rise[1] && pending_q[1]) begin
                    state_d    = S_WALK;
                    walk_p_d   = 1'b1;
                    ped_clr[1] = 1'b1;
                end
            end
            S_WALK: begin
                if (emv_any || cnt_done) state_d = S_FLASH;
            end
            S_FLASH: begin
                if (cnt_done) begin
                    if (emv_any) begin
                        state_d  = S_EMV_SEEK;
                        target_d = emv_sel;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_EMV_SEEK: begin
                if (pcnt_max) begin
                    state_d   = S_EMV_LOCK;
                    timeout_d = 1'b1;
                end else if (!bus.emv_req[target_q]) begin
                    // Vehicle withdrew before arrival: chase the other approach if present.
                    if (bus.emv_req[~target_q]) target_d = ~target_q;
                    else                        state_d  = S_IDLE;
                end else if (green_d[target_q]) begin
                    state_d = S_EMV_HOLD;
                end
            end
            S_EMV_HOLD: begin
                if (pcnt_max) begin
                    state_d   = S_EMV_LOCK;
                    timeout_d = 1'b1;
                end else if (!bus.emv_req[target_q] && cnt_done) begin
                    state_d = S_IDLE;
                end
            end
            S_EMV_LOCK: begin
                if (!emv_any) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // pcnt holds the number of preemption cycles including the current one.
    always_comb begin
        in_preempt = (state_d == S_EMV_SEEK) || (state_d == S_EMV_HOLD);
        seek_entry = (state_d == S_EMV_SEEK) &&
                     ((state_q != S_EMV_SEEK) || (target_d != target_q));
        cnt_d = cnt_q;
        if (state_d == S_WALK && state_q != S_WALK)              cnt_d = WALK_LOAD;
        else if (state_d == S_FLASH && state_q != S_FLASH)       cnt_d = FLASH_LOAD;
        else if (state_d == S_EMV_HOLD && state_q != S_EMV_HOLD) cnt_d = MIN_LOAD;
        else if (!cnt_done)                                      cnt_d = cnt_q - 16'd1;
        pcnt_d = 16'd0;
        if (seek_entry)                         pcnt_d = 16'd1;
        else if (in_preempt && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
        else if (in_preempt)                    pcnt_d = pcnt_q;
        pending_d = (pending_q & ~ped_clr) | bus.ped_req;
    end

    always_comb begin
        walk_d    = 2'b00;
        flash_d   = 2'b00;
        hold_d    = 1'b0;
        preempt_d = 1'b0;
        pphase_d  = 1'b0;
        case (state_d)
            S_WALK: begin
                walk_d[walk_p_d] = 1'b1;
                hold_d           = 1'b1;
            end
            S_FLASH: begin
                flash_d[walk_p_d] = 1'b1;
                hold_d            = 1'b1;
            end
            S_EMV_SEEK: begin
                preempt_d = 1'b1;
                pphase_d  = target_d;
            end
            S_EMV_HOLD: begin
                preempt_d = 1'b1;
                pphase_d  = target_d;
                hold_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            pcnt_q    <= 16'd0;
            walk_p_q  <= 1'b0;
            target_q  <= 1'b0;
            green_q   <= 2'b00;
            pending_q <= 2'b00;
            timeout_q <= 1'b0;
            walk_q    <= 2'b00;
            flash_q   <= 2'b00;
            hold_q    <= 1'b0;
            preempt_q <= 1'b0;
            pphase_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            walk_p_q  <= walk_p_d;
            target_q  <= target_d;
            green_q   <= green_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            walk_q    <= walk_d;
            flash_q   <= flash_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
            pphase_q  <= pphase_d;
        end
    end

    assign bus.preempt       = preempt_q;
    assign bus.preempt_phase = pphase_q;
    assign bus.hold_green    = hold_q;
    assign bus.ped_pending   = pending_q;
    assign bus.ped_walk      = walk_q;
    assign bus.ped_flash     = flash_q;
    assign bus.emv_timeout   = timeout_q;

endmodule

// File: tb/tb_intersection_request_scheduler.sv
// Directed bench for intersection_request_scheduler: pedestrian service,
// EMV preemption, retargeting, minimum hold, timeout lockout and async reset.
module tb_intersection_request_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    intersection_request_scheduler_if ifc();

    intersection_request_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_green(input logic p);
        ifc.yellow = 1'b1;
        step();
        ifc.yellow       = 1'b0;
        ifc.all_red      = 1'b1;
        ifc.active_phase = {1'b0, p};
        step();
        ifc.all_red = 1'b0;
    endtask

    function automatic logic [9:0] all_outs();
        return {ifc.ped_pending, ifc.ped_walk, ifc.ped_flash, ifc.hold_green,
                ifc.preempt, ifc.preempt_phase, ifc.emv_timeout};
    endfunction

    task automatic test_reset();
        ifc.ped_req = 2'b00; ifc.emv_req = 2'b00; ifc.active_phase = 2'd0;
        ifc.yellow = 1'b0; ifc.all_red = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if (all_outs() !== 10'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %b expected %b", all_outs(), 10'd0);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (all_outs() !== 10'd0) begin
            miscompares++; $display("FAIL post_reset_idle: got %b expected %b", all_outs(), 10'd0);
        end
    endtask

    task automatic test_ped_service();
        ifc.active_phase = 2'd1; ifc.all_red = 1'b0;
        step();
        ifc.ped_req = 2'b01;
        step();
        ifc.ped_req = 2'b00;
        vectors++;
        if (ifc.ped_pending !== 2'b01) begin
            miscompares++; $display("FAIL ped_latch: got %b expected 01", ifc.ped_pending);
        end
        go_green(1'b0);
        vectors++;
        if (ifc.ped_pending !== 2'b01 || ifc.ped_walk !== 2'b00) begin
            miscompares++;
            $display("FAIL ped_wait_rise: pending %b walk %b expected 01/00", ifc.ped_pending, ifc.ped_walk);
        end
        step();
        vectors++;
        if (ifc.ped_pending !== 2'b00) begin
            miscompares++; $display("FAIL ped_clear: got %b expected 00", ifc.ped_pending);
        end
        for (int i = 0; i < 700; i++) begin
            vectors++;
            if (ifc.ped_walk !== 2'b01 || ifc.ped_flash !== 2'b00 || ifc.hold_green !== 1'b1) begin
                miscompares++;
                $display("FAIL walk_window c%0d: walk %b flash %b hold %b expected 01/00/1",
                         i, ifc.ped_walk, ifc.ped_flash, ifc.hold_green);
            end
            step();
        end
        for (int i = 0; i < 500; i++) begin
            vectors++;
            if (ifc.ped_walk !== 2'b00 || ifc.ped_flash !== 2'b01 || ifc.hold_green !== 1'b1) begin
                miscompares++;
                $display("FAIL flash_window c%0d: walk %b flash %b hold %b expected 00/01/1",
                         i, ifc.ped_walk, ifc.ped_flash, ifc.hold_green);
            end
            step();
        end
        vectors++;
        if (ifc.ped_walk !== 2'b00 || ifc.ped_flash !== 2'b00 || ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL ped_done: walk %b flash %b hold %b expected 00/00/0",
                     ifc.ped_walk, ifc.ped_flash, ifc.hold_green);
        end
    endtask

    task automatic test_emv_during_walk();
        ifc.ped_req = 2'b10;
        step();
        ifc.ped_req = 2'b00;
        go_green(1'b1);
        step();
        repeat (99) step();
        vectors++;
        if (ifc.ped_walk !== 2'b10) begin
            miscompares++; $display("FAIL walk_ew_c100: got %b expected 10", ifc.ped_walk);
        end
        ifc.emv_req = 2'b10;
        step();
        for (int i = 0; i < 500; i++) begin
            vectors++;
            if (ifc.ped_walk !== 2'b00 || ifc.ped_flash !== 2'b10 || ifc.preempt !== 1'b0) begin
                miscompares++;
                $display("FAIL early_flash c%0d: walk %b flash %b preempt %b expected 00/10/0",
                         i, ifc.ped_walk, ifc.ped_flash, ifc.preempt);
            end
            step();
        end
        vectors++;
        if (ifc.preempt !== 1'b1 || ifc.preempt_phase !== 1'b1 || ifc.ped_flash !== 2'b00 ||
            ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL seek_after_flash: preempt %b phase %b flash %b hold %b expected 1/1/00/0",
                     ifc.preempt, ifc.preempt_phase, ifc.ped_flash, ifc.hold_green);
        end
        step();
        vectors++;
        if (ifc.hold_green !== 1'b1 || ifc.preempt !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_ew: hold %b preempt %b expected 1/1", ifc.hold_green, ifc.preempt);
        end
        ifc.emv_req = 2'b00;
        for (int i = 1; i < 500; i++) begin
            step();
            vectors++;
            if (ifc.preempt !== 1'b1) begin
                miscompares++; $display("FAIL hold_ew_min c%0d: preempt %b expected 1", i, ifc.preempt);
            end
        end
        step();
        vectors++;
        if (ifc.preempt !== 1'b0 || ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_ew_release: preempt %b hold %b expected 0/0", ifc.preempt, ifc.hold_green);
        end
    endtask

    task automatic test_simultaneous_emv();
        ifc.all_red = 1'b1;
        step();
        ifc.emv_req = 2'b11;
        step();
        vectors++;
        if (ifc.preempt !== 1'b1 || ifc.preempt_phase !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_priority: preempt %b phase %b expected 1/0", ifc.preempt, ifc.preempt_phase);
        end
        step();
        vectors++;
        if (ifc.preempt_phase !== 1'b0 || ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_seeking: phase %b hold %b expected 0/0", ifc.preempt_phase, ifc.hold_green);
        end
        ifc.emv_req = 2'b10;
        step();
        vectors++;
        if (ifc.preempt !== 1'b1 || ifc.preempt_phase !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_retarget: preempt %b phase %b expected 1/1", ifc.preempt, ifc.preempt_phase);
        end
        ifc.active_phase = 2'd1; ifc.all_red = 1'b0;
        step();
        vectors++;
        if (ifc.hold_green !== 1'b1 || ifc.preempt_phase !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_hold: hold %b phase %b expected 1/1", ifc.hold_green, ifc.preempt_phase);
        end
        ifc.emv_req = 2'b00;
        repeat (499) step();
        vectors++;
        if (ifc.preempt !== 1'b1) begin
            miscompares++; $display("FAIL sim_min_last: preempt %b expected 1", ifc.preempt);
        end
        step();
        vectors++;
        if (ifc.preempt !== 1'b0) begin
            miscompares++; $display("FAIL sim_release: preempt %b expected 0", ifc.preempt);
        end
    endtask

    task automatic test_min_hold();
        ifc.all_red = 1'b1; ifc.active_phase = 2'd0;
        ifc.emv_req = 2'b01;
        step();
        vectors++;
        if (ifc.preempt !== 1'b1 || ifc.preempt_phase !== 1'b0) begin
            miscompares++;
            $display("FAIL min_seek: preempt %b phase %b expected 1/0", ifc.preempt, ifc.preempt_phase);
        end
        ifc.all_red = 1'b0;
        step();
        vectors++;
        if (ifc.hold_green !== 1'b1) begin
            miscompares++; $display("FAIL min_hold_entry: hold %b expected 1", ifc.hold_green);
        end
        repeat (9) step();
        ifc.emv_req = 2'b00;
        for (int i = 10; i <= 500; i++) begin
            vectors++;
            if (ifc.preempt !== 1'b1) begin
                miscompares++; $display("FAIL min_hold c%0d: preempt %b expected 1", i, ifc.preempt);
            end
            step();
        end
        vectors++;
        if (ifc.preempt !== 1'b0 || ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL min_release: preempt %b hold %b expected 0/0", ifc.preempt, ifc.hold_green);
        end
    endtask

    task automatic test_timeout();
        ifc.emv_req = 2'b01;
        step();
        for (int i = 1; i <= 6000; i++) begin
            vectors++;
            if (ifc.preempt !== 1'b1 || ifc.emv_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL to_active c%0d: preempt %b timeout %b expected 1/0", i, ifc.preempt, ifc.emv_timeout);
            end
            step();
        end
        vectors++;
        if (ifc.preempt !== 1'b0 || ifc.emv_timeout !== 1'b1 || ifc.hold_green !== 1'b0) begin
            miscompares++;
            $display("FAIL to_expire: preempt %b timeout %b hold %b expected 0/1/0",
                     ifc.preempt, ifc.emv_timeout, ifc.hold_green);
        end
        for (int i = 6001; i < 7000; i++) begin
            step();
            vectors++;
            if (ifc.preempt !== 1'b0) begin
                miscompares++; $display("FAIL to_locked c%0d: preempt %b expected 0", i, ifc.preempt);
            end
        end
        ifc.emv_req = 2'b00;
        step();
        vectors++;
        if (ifc.preempt !== 1'b0 || ifc.emv_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL to_unlock: preempt %b timeout %b expected 0/1", ifc.preempt, ifc.emv_timeout);
        end
        ifc.emv_req = 2'b01;
        step();
        vectors++;
        if (ifc.preempt !== 1'b1 || ifc.emv_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL to_repreempt: preempt %b timeout %b expected 1/1", ifc.preempt, ifc.emv_timeout);
        end
    endtask

    task automatic test_reset_mid_preempt();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (all_outs() !== 10'd0) begin
            miscompares++; $display("FAIL async_reset: got %b expected %b", all_outs(), 10'd0);
        end
        ifc.emv_req = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (all_outs() !== 10'd0) begin
            miscompares++; $display("FAIL reset_release: got %b expected %b", all_outs(), 10'd0);
        end
    endtask

    initial begin
        test_reset();
        test_ped_service();
        test_emv_during_walk();
        test_simultaneous_emv();
        test_min_hold();
        test_timeout();
        test_reset_mid_preempt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
